// File: rtl/ps2_kbd_if.sv
// PS/2 keyboard line and decoded-key bundle between the keyboard side and ps2_kbd_decoder.
interface ps2_kbd_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       is_press;
   logic [7:0] count;
   logic [7:0] key;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  is_press, count, key, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output is_press, count, key, frame_err
   );
endinterface

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver plus make/break decoder producing key, pressed flag and press count.
// Optional odd-parity frame check is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_kbd_decoder #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic      clk,
   input  logic      rst,
   ps2_kbd_if.slave  bus
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [0:0] {
      ST_MAKE  = 1'b0,
      ST_BREAK = 1'b1
   } state_t;

   function automatic logic odd_parity_ok(input logic [8:0] bits);
      return ^bits;
   endfunction

   logic [2:0]      ps2_clk_sync_r;
   logic [1:0]      ps2_data_sync_r;
   logic [3:0]      bit_cnt_r, bit_cnt_nxt;
   logic [9:0]      shift_r, shift_nxt;
   logic [WD_W-1:0] wd_cnt_r, wd_cnt_nxt;
   state_t          state_r, state_nxt;
   logic [7:0]      key_r, key_nxt;
   logic [7:0]      count_r, count_nxt;
   logic            press_r, press_nxt;
   logic            err_r, err_nxt;

   logic            fall_s;
   logic            frame_done_s;
   logic            timeout_s;
   logic            par_ok_s;
   logic            frame_ok_s;
   logic [10:0]     frame_s;
   logic [7:0]      byte_s;

   // Line synchronizers; ps2_clk gets a third stage for falling-edge detection.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ps2_clk_sync_r  <= 3'b111;
         ps2_data_sync_r <= 2'b11;
      end else begin
         ps2_clk_sync_r  <= {ps2_clk_sync_r[1:0], bus.ps2_clk};
         ps2_data_sync_r <= {ps2_data_sync_r[0], bus.ps2_data};
      end
   end

   assign fall_s       = ps2_clk_sync_r[2] & ~ps2_clk_sync_r[1];
   assign frame_s      = {ps2_data_sync_r[1], shift_r};
   assign byte_s       = frame_s[8:1];
   assign frame_done_s = fall_s && (bit_cnt_r == 4'd10);
   assign timeout_s    = !fall_s && (bit_cnt_r != 4'd0) &&
                         (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
   assign par_ok_s = odd_parity_ok(frame_s[9:1]);
`else
   // Parity bit is a don't-care in this build.
   assign par_ok_s = 1'b1 | frame_s[9];
`endif

   assign frame_ok_s = !frame_s[0] && frame_s[10] && par_ok_s;

   // Bit counter, shift register and watchdog next-state.
   always_comb begin
      bit_cnt_nxt = bit_cnt_r;
      shift_nxt   = shift_r;
      wd_cnt_nxt  = wd_cnt_r;
      if (fall_s) begin
         wd_cnt_nxt = '0;
         if (bit_cnt_r == 4'd10) begin
            bit_cnt_nxt = 4'd0;
         end else begin
            shift_nxt   = {ps2_data_sync_r[1], shift_r[9:1]};
            bit_cnt_nxt = bit_cnt_r + 4'd1;
         end
      end else if (timeout_s) begin
         bit_cnt_nxt = 4'd0;
         wd_cnt_nxt  = '0;
      end else if (bit_cnt_r != 4'd0) begin
         wd_cnt_nxt = wd_cnt_r + WD_W'(1);
      end else begin
         wd_cnt_nxt = '0;
      end
   end

   // Make/break decoder next-state and output values.
   always_comb begin
      state_nxt = state_r;
      key_nxt   = key_r;
      count_nxt = count_r;
      press_nxt = press_r;
      err_nxt   = 1'b0;
      if (timeout_s) begin
         err_nxt = 1'b1;
      end else if (frame_done_s && !frame_ok_s) begin
         err_nxt = 1'b1;
      end else if (frame_done_s) begin
         case (state_r)
            ST_MAKE: begin
               if (byte_s == 8'hF0) begin
                  state_nxt = ST_BREAK;
               end else if (byte_s == 8'hE0) begin
                  state_nxt = ST_MAKE;
               end else if ((byte_s == key_r) && press_r) begin
                  state_nxt = ST_MAKE;
               end else begin
                  key_nxt   = byte_s;
                  press_nxt = 1'b1;
                  count_nxt = count_r + 8'd1;
               end
            end
            ST_BREAK: begin
               if (byte_s == 8'hE0) begin
                  state_nxt = ST_BREAK;
               end else begin
                  // Releasing some other key leaves the displayed key's flag alone.
                  if (byte_s == key_r) begin
                     press_nxt = 1'b0;
                  end else begin
                     press_nxt = press_r;
                  end
                  state_nxt = ST_MAKE;
               end
            end
            default: state_nxt = ST_MAKE;
         endcase
      end else begin
         err_nxt = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bit_cnt_r <= 4'd0;
         shift_r   <= 10'd0;
         wd_cnt_r  <= '0;
         state_r   <= ST_MAKE;
         key_r     <= 8'h00;
         count_r   <= 8'h00;
         press_r   <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         bit_cnt_r <= bit_cnt_nxt;
         shift_r   <= shift_nxt;
         wd_cnt_r  <= wd_cnt_nxt;
         state_r   <= state_nxt;
         key_r     <= key_nxt;
         count_r   <= count_nxt;
         press_r   <= press_nxt;
         err_r     <= err_nxt;
      end
   end

   assign bus.key       = key_r;
   assign bus.count     = count_r;
   assign bus.is_press  = press_r;
   assign bus.frame_err = err_r;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Scoreboard bench for ps2_kbd_decoder: expected per-frame snapshots queued at drive time.
module tb_ps2_kbd_decoder;

   localparam int TIMEOUT = 300;
   localparam int HP      = 5;

   typedef struct packed {
      logic [7:0] key;
      logic [7:0] count;
      logic       press;
      logic [7:0] errs;
   } snap_t;

   logic clk;
   logic rst;
   ps2_kbd_if bus();

   ps2_kbd_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    n_cmp = 0;
   int    n_bad = 0;
   int    err_pulses = 0;
   int    err_run = 0;
   int    err_max_run = 0;
   snap_t exp_q[$];
   snap_t obs_q[$];

   // frame_err pulse counter and widest-pulse tracker
   always @(negedge clk) begin
      if (bus.frame_err === 1'b1) begin
         if (err_run == 0) err_pulses = err_pulses + 1;
         err_run = err_run + 1;
         if (err_run > err_max_run) err_max_run = err_run;
      end else begin
         err_run = 0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic snap_t mk(input logic [7:0] k, input logic [7:0] c,
                                input logic p, input logic [7:0] e);
      snap_t s;
      s.key = k; s.count = c; s.press = p; s.errs = e;
      return s;
   endfunction

   task automatic drive_bits(input logic [10:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = f[i];
         tick(HP);
         bus.ps2_clk = 1'b0;
         tick(HP);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
   endtask

   // fault: 0 none, 1 stop bit low, 2 parity flipped, 3 start bit high
   task automatic send_frame(input logic [7:0] b, input int fault, input snap_t e);
      logic [10:0] f;
      int          base;
      snap_t       o;
      f = {1'b1, ~^b, b, 1'b0};
      if (fault == 1) f[10] = 1'b0;
      if (fault == 2) f[9]  = ~f[9];
      if (fault == 3) f[0]  = 1'b1;
      exp_q.push_back(e);
      base = err_pulses;
      drive_bits(f, 11);
      tick(3);
      o = mk(bus.key, bus.count, bus.is_press, 8'(err_pulses - base));
      obs_q.push_back(o);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      do_reset();
      n_cmp++; if (bus.key !== 8'h00)     begin n_bad++; $display("FAIL reset_key: got %h want 00", bus.key); end
      n_cmp++; if (bus.count !== 8'h00)   begin n_bad++; $display("FAIL reset_count: got %h want 00", bus.count); end
      n_cmp++; if (bus.is_press !== 1'b0) begin n_bad++; $display("FAIL reset_press: got %b want 0", bus.is_press); end
      n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
   endtask

   task automatic test_make_break();
      snap_t e, o;
      do_reset();
      send_frame(8'h1C, 0, mk(8'h1C, 8'h01, 1'b1, 8'd0));
      send_frame(8'hF0, 0, mk(8'h1C, 8'h01, 1'b1, 8'd0));
      send_frame(8'h1C, 0, mk(8'h1C, 8'h01, 1'b0, 8'd0));
      // extended key: E0 prefix dropped on make and on break
      send_frame(8'hE0, 0, mk(8'h1C, 8'h01, 1'b0, 8'd0));
      send_frame(8'h75, 0, mk(8'h75, 8'h02, 1'b1, 8'd0));
      send_frame(8'hE0, 0, mk(8'h75, 8'h02, 1'b1, 8'd0));
      send_frame(8'hF0, 0, mk(8'h75, 8'h02, 1'b1, 8'd0));
      send_frame(8'hE0, 0, mk(8'h75, 8'h02, 1'b1, 8'd0));
      send_frame(8'h75, 0, mk(8'h75, 8'h02, 1'b0, 8'd0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL make_break: got %h want %h", o, e); end
      end
   endtask

   task automatic test_typematic();
      snap_t e, o;
      do_reset();
      for (int i = 0; i < 5; i++) send_frame(8'h1C, 0, mk(8'h1C, 8'h01, 1'b1, 8'd0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL typematic: got %h want %h", o, e); end
      end
   endtask

   task automatic test_two_keys();
      snap_t e, o;
      do_reset();
      send_frame(8'h1C, 0, mk(8'h1C, 8'h01, 1'b1, 8'd0));
      send_frame(8'h32, 0, mk(8'h32, 8'h02, 1'b1, 8'd0));
      send_frame(8'hF0, 0, mk(8'h32, 8'h02, 1'b1, 8'd0));
      send_frame(8'h1C, 0, mk(8'h32, 8'h02, 1'b1, 8'd0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL two_keys: got %h want %h", o, e); end
      end
   endtask

   task automatic test_bad_frames();
      snap_t e, o;
      do_reset();
`ifdef PS2_PARITY_CHECK_EN
      send_frame(8'h1C, 2, mk(8'h00, 8'h00, 1'b0, 8'd1));
`else
      send_frame(8'h1C, 2, mk(8'h1C, 8'h01, 1'b1, 8'd0));
`endif
      send_frame(8'h1C, 0, mk(8'h1C, 8'h01, 1'b1, 8'd0));
      send_frame(8'h32, 1, mk(8'h1C, 8'h01, 1'b1, 8'd1));
      send_frame(8'h32, 3, mk(8'h1C, 8'h01, 1'b1, 8'd1));
      send_frame(8'hF0, 0, mk(8'h1C, 8'h01, 1'b1, 8'd0));
      send_frame(8'h1C, 0, mk(8'h1C, 8'h01, 1'b0, 8'd0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL bad_frames: got %h want %h", o, e); end
      end
   endtask

   task automatic test_wrap();
      snap_t e, o;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] b;
         b = (i % 2 == 1) ? 8'h32 : 8'h1C;
         send_frame(b, 0, mk(b, 8'(i + 1), 1'b1, 8'd0));
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL wrap: got %h want %h", o, e); end
      end
   endtask

   // Continues from the wrap state: key 32, count 00, pressed.
   task automatic test_timeout();
      snap_t e, o;
      int    base;
      exp_q.push_back(mk(8'h32, 8'h00, 1'b1, 8'd1));
      base = err_pulses;
      drive_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
      tick(TIMEOUT + 30);
      obs_q.push_back(mk(bus.key, bus.count, bus.is_press, 8'(err_pulses - base)));
      send_frame(8'h21, 0, mk(8'h21, 8'h01, 1'b1, 8'd0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL timeout: got %h want %h", o, e); end
      end
   endtask

   task automatic test_reset_midframe();
      snap_t e, o;
      do_reset();
      drive_bits({1'b1, 1'b0, 8'h32, 1'b0}, 5);
      do_reset();
      send_frame(8'h1C, 0, mk(8'h1C, 8'h01, 1'b1, 8'd0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL reset_midframe: got %h want %h", o, e); end
      end
   endtask

   task automatic test_err_width();
      n_cmp++;
      if (err_max_run !== 1) begin
         n_bad++;
         $display("FAIL err_width: got %0d cycles want 1", err_max_run);
      end
   endtask

   initial begin
      rst          = 1'b0;
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      test_reset();
      test_make_break();
      test_typematic();
      test_two_keys();
      test_bad_frames();
      test_wrap();
      test_timeout();
      test_reset_midframe();
      test_err_width();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
